cnn_window_mac_seq: RTL and testbench

//  Sequencer for one 7x7 convolution window. On start, walks the 49-element window buffer through the

---
 rtl/cnn_pkg.sv | 21 ++
 rtl/cnn_mac_stage.sv | 39 +++
 rtl/cnn_window_mac_seq.sv | 90 +++++++++
 tb/tb_cnn_window_mac_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the 7x7 convolution window sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnn_pkg;

  localparam int WIN    = 7;
  localparam int DATA_W = 16;
  localparam int N      = WIN * WIN;
  // Worst case 49 * (-32768)^2 needs 2*DATA_W product bits plus clog2(N) growth.
  localparam int ACC_W  = 2 * DATA_W + $clog2(N);
  localparam int IDX_W  = $clog2(WIN);
  localparam int ADDR_W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/cnn_mac_stage.sv
// Registered signed multiply followed by a clearable, enabled accumulator.
// Latency: operands presented in cycle k land in acc at the end of cycle k+1.
// Backpressure: none; every in_valid cycle is consumed.
// Ports: clk, rst (sync, active-high), a/b operands, in_valid, clr (zero acc), acc result.
module cnn_mac_stage
  import cnn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic                     in_valid,
  input  logic                     clr,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] p_dat;
  logic                       p_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_dat   <= '0;
      p_valid <= 1'b0;
      acc     <= '0;
    end else begin
      p_valid <= in_valid;
      if (in_valid) begin
        p_dat <= a * b;
      end
      // Clear wins over accumulate so a new pass always starts from zero.
      if (clr) begin
        acc <= '0;
      end else if (p_valid) begin
        acc <= acc + {{(ACC_W-2*DATA_W){p_dat[2*DATA_W-1]}}, p_dat};
      end
    end
  end

endmodule

// File: rtl/cnn_window_mac_seq.sv
// Walks a 7x7 window row-major, fetches matching weights and returns their dot product.
// Latency: start accepted in c0 -> out_valid first high in c0+N+2.
// Backpressure: result held in HOLD with out_valid high until out_ready; start ignored while busy.
// Ports: clk, rst, start, busy; sel_x/sel_y/sel_data to the element selector;
//        weight_addr/weight_data to the kernel store; out_valid/out_ready/out_data result handshake.
module cnn_window_mac_seq
  import cnn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic [IDX_W-1:0]         sel_x,
  output logic [IDX_W-1:0]         sel_y,
  input  logic signed [DATA_W-1:0] sel_data,
  output logic [ADDR_W-1:0]        weight_addr,
  input  logic signed [DATA_W-1:0] weight_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data
);

  state_t state;
  logic   acc_clr;
  logic   mac_vld;

  assign acc_clr = (state == IDLE) && start;
  assign mac_vld = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      sel_x       <= '0;
      sel_y       <= '0;
      weight_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            sel_x       <= '0;
            sel_y       <= '0;
            weight_addr <= '0;
          end
        end
        RUN: begin
          // Indices stop on the last element and hold there until the next pass.
          if (weight_addr == ADDR_W'(N-1)) begin
            state <= DRAIN;
          end else begin
            weight_addr <= weight_addr + ADDR_W'(1);
            if (sel_y == IDX_W'(WIN-1)) begin
              sel_y <= '0;
              sel_x <= sel_x + IDX_W'(1);
            end else begin
              sel_y <= sel_y + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          state     <= HOLD;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The accumulator only changes during RUN/DRAIN, so it is stable through HOLD.
  cnn_mac_stage u_mac (
    .clk      (clk),
    .rst      (rst),
    .a        (sel_data),
    .b        (weight_data),
    .in_valid (mac_vld),
    .clr      (acc_clr),
    .acc      (out_data)
  );

endmodule

// File: tb/tb_cnn_window_mac_seq.sv
module tb_cnn_window_mac_seq;
  import cnn_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     start = 1'b0;
  logic                     busy;
  logic [IDX_W-1:0]         sel_x;
  logic [IDX_W-1:0]         sel_y;
  logic signed [DATA_W-1:0] sel_data;
  logic [ADDR_W-1:0]        weight_addr;
  logic signed [DATA_W-1:0] weight_data;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic signed [ACC_W-1:0]  out_data;

  logic [DATA_W-1:0] elem [0:63];
  logic [DATA_W-1:0] wgt  [0:63];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Selector and weight store are combinational lookups into bench tables.
  assign sel_data    = elem[int'(sel_x) * WIN + int'(sel_y)];
  assign weight_data = wgt[int'(weight_addr)];

  cnn_window_mac_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .sel_x       (sel_x),
    .sel_y       (sel_y),
    .sel_data    (sel_data),
    .weight_addr (weight_addr),
    .weight_data (weight_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint model_dot();
    longint s = 0;
    for (int i = 0; i < N; i++)
      s += longint'($signed(elem[i])) * longint'($signed(wgt[i]));
    return s;
  endfunction

  task automatic fill_const(input logic [DATA_W-1:0] e, input logic [DATA_W-1:0] w);
    for (int i = 0; i < 64; i++) begin
      elem[i] = e;
      wgt[i]  = w;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start, traces the index walk, and returns with the DUT in HOLD.
  task automatic run_to_valid(input longint exp);
    int cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 120) begin
      if (cyc <= N) begin
        check("trace_x", longint'(sel_x), longint'((cyc - 1) / WIN));
        check("trace_y", longint'(sel_y), longint'((cyc - 1) % WIN));
        check("trace_addr", longint'(weight_addr), longint'(cyc - 1));
      end
      check("busy_run", longint'(busy), 1);
      tick();
      cyc++;
    end
    check("valid_cycle", longint'(cyc), longint'(N + 2));
    check("out_data", longint'(out_data), exp);
    check("hold_addr", longint'({sel_x, sel_y, weight_addr}), longint'({3'd6, 3'd6, 6'd48}));
  endtask

  task automatic finish_handshake();
    out_ready = 1'b1;
    tick();
    check("idle_busy", longint'(busy), 0);
    check("idle_valid", longint'(out_valid), 0);
  endtask

  initial begin
    fill_const(16'd1, 16'd1);
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", longint'(busy), 0);
    check("rst_valid", longint'(out_valid), 0);
    check("rst_sel", longint'({sel_x, sel_y, weight_addr}), 0);
    check("rst_data", longint'(out_data), 0);

    // Ones: 49.
    run_to_valid(64'sd49);
    finish_handshake();

    // Ramp elements, unit weights: sum 0..48.
    for (int i = 0; i < N; i++) begin
      elem[i] = DATA_W'(i);
      wgt[i]  = 16'd1;
    end
    run_to_valid(64'sd1176);
    finish_handshake();

    fill_const(16'hFFFE, 16'd3);
    run_to_valid(-64'sd294);
    finish_handshake();

    fill_const(16'h8000, 16'h8000);
    run_to_valid(64'sd52613349376);
    finish_handshake();

    // Random operands checked against the plain-arithmetic model.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 64; i++) begin
        elem[i] = DATA_W'($urandom);
        wgt[i]  = DATA_W'($urandom);
      end
      run_to_valid(model_dot());
      finish_handshake();
    end

    // Held result with stalled consumer; start during HOLD is ignored.
    for (int i = 0; i < 64; i++) begin
      elem[i] = DATA_W'($urandom);
      wgt[i]  = DATA_W'($urandom);
    end
    begin
      longint exp5;
      exp5 = model_dot();
      out_ready = 1'b0;
      run_to_valid(exp5);
      for (int k = 0; k < 10; k++) begin
        start = (k == 3);
        tick();
        check("hold_valid", longint'(out_valid), 1);
        check("hold_data", longint'(out_data), exp5);
        check("hold_busy", longint'(busy), 1);
      end
      // Start coincident with the handshake edge must not be queued.
      start = 1'b1;
      finish_handshake();
      start = 1'b0;
      tick();
      check("no_queue_busy", longint'(busy), 0);
      check("no_queue_addr", longint'(weight_addr), 48);
    end

    // Reset mid-run at index 20, then a fresh pass.
    fill_const(16'd1, 16'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check("idx20", longint'(weight_addr), 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", longint'(busy), 0);
    check("abort_valid", longint'(out_valid), 0);
    check("abort_sel", longint'({sel_x, sel_y, weight_addr}), 0);
    check("abort_data", longint'(out_data), 0);
    tick();
    run_to_valid(64'sd49);
    finish_handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
